// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline register sequencing for the 16-bit five-stage core
// Resolves load-use, branch flush, memory stalls and HLT drain; counts RUN stall cycles.
module pipeline_hazard_ctrl #(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       id_rs,
   input  logic [3:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_memread,
   input  logic [3:0]       ex_rd,
   input  logic             id_branch_taken,
   input  logic             id_hlt,
   input  logic             imem_stall,
   input  logic             dmem_stall,
   output logic             pc_wen,
   output logic             ifid_wen,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             exmem_wen,
   output logic             memwb_wen,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_DRAIN   = 2'd1;
   localparam logic [1:0] ST_HALTED  = 2'd2;
   localparam logic [1:0] DRAIN_INIT = DRAIN_CYCLES[1:0];
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       state_q, state_d;
   logic [1:0]       drain_cnt_q, drain_cnt_d;
   logic             halted_q, halted_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic             load_use;

   // R0 is hardwired zero, so a load targeting it can never feed a hazard.
   always_comb begin
      load_use = ex_memread && (ex_rd != 4'd0) &&
                 ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
   end

   always_comb begin
      pc_wen         = 1'b0;
      ifid_wen       = 1'b0;
      ifid_flush     = 1'b0;
      idex_bubble    = 1'b0;
      exmem_wen      = 1'b0;
      memwb_wen      = 1'b0;
      state_d        = state_q;
      drain_cnt_d    = drain_cnt_q;
      halted_d       = halted_q;
      stall_cycles_d = stall_cycles_q;

      case (state_q)
         ST_RUN: begin
            if (dmem_stall) begin
               pc_wen = 1'b0;
            end else if (load_use) begin
               idex_bubble = 1'b1;
               exmem_wen   = 1'b1;
               memwb_wen   = 1'b1;
            end else if (id_hlt) begin
               ifid_wen    = 1'b1;
               ifid_flush  = 1'b1;
               exmem_wen   = 1'b1;
               memwb_wen   = 1'b1;
               state_d     = ST_DRAIN;
               drain_cnt_d = DRAIN_INIT;
            end else if (id_branch_taken) begin
               pc_wen     = 1'b1;
               ifid_wen   = 1'b1;
               ifid_flush = 1'b1;
               exmem_wen  = 1'b1;
               memwb_wen  = 1'b1;
            end else if (imem_stall) begin
               ifid_wen   = 1'b1;
               ifid_flush = 1'b1;
               exmem_wen  = 1'b1;
               memwb_wen  = 1'b1;
            end else begin
               pc_wen    = 1'b1;
               ifid_wen  = 1'b1;
               exmem_wen = 1'b1;
               memwb_wen = 1'b1;
            end
            if (!pc_wen && (stall_cycles_q != {CNT_W{1'b1}})) begin
               stall_cycles_d = stall_cycles_q + CNT_ONE;
            end
         end
         ST_DRAIN: begin
            idex_bubble = 1'b1;
            exmem_wen   = !dmem_stall;
            memwb_wen   = !dmem_stall;
            // A stalled data memory holds the tail instructions, so the drain waits too.
            if (!dmem_stall) begin
               drain_cnt_d = drain_cnt_q - 2'd1;
               if (drain_cnt_q == 2'd1) begin
                  state_d  = ST_HALTED;
                  halted_d = 1'b1;
               end
            end
         end
         ST_HALTED: begin
            idex_bubble = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      if (rst) begin
         pc_wen      = 1'b0;
         ifid_wen    = 1'b0;
         ifid_flush  = 1'b0;
         idex_bubble = 1'b0;
         exmem_wen   = 1'b0;
         memwb_wen   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_RUN;
         drain_cnt_q    <= 2'd0;
         halted_q       <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         drain_cnt_q    <= drain_cnt_d;
         halted_q       <= halted_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign halted       = halted_q;
   assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline sequencing controller for the 16-bit five-stage core. It generates the write-enable, flush and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch flushes, instruction/data memory stalls and HLT drain. A saturating stall-cycle counter is exposed for performance measurement.

## Interface
Parameters:
- DRAIN_CYCLES, 3: cycles after HLT leaves ID before `halted` asserts (EX, MEM, WB).
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  4  rs field of the instruction in IF/ID.
- id_rt  in  4  rt field of the instruction in IF/ID.
- id_uses_rs  in  1  the ID instruction reads rs.
- id_uses_rt  in  1  the ID instruction reads rt.
- ex_memread  in  1  MemRead of the instruction in ID/EX.
- ex_rd  in  4  destination register of the instruction in ID/EX.
- id_branch_taken  in  1  the branch resolved in ID is taken.
- id_hlt  in  1  the instruction in ID is HLT.
- imem_stall  in  1  instruction memory not ready this cycle.
- dmem_stall  in  1  data memory not ready this cycle.
- pc_wen  out  1  PC register write enable.
- ifid_wen  out  1  IF/ID write enable.
- ifid_flush  out  1  load NOP into IF/ID on this edge.
- idex_bubble  out  1  load all-zero controls into ID/EX on this edge.
- exmem_wen  out  1  EX/MEM write enable.
- memwb_wen  out  1  MEM/WB write enable.
- halted  out  1  processor halted (registered).
- stall_cycles  out  CNT_W  saturating count of cycles with pc_wen=0 in RUN.

## Operation
- State machine: RUN, DRAIN, HALTED. Registered state holds `state`, `drain_cnt` (2 bits), `stall_cycles` and `halted`.
- Load-use hazard: load_use = ex_memread & ex_rd≠0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
  - R0 never creates a hazard.
- RUN control decode. The first matching rule applies.
  1. dmem_stall: freeze the whole pipeline. All five wen outputs are 0, ifid_flush=0, idex_bubble=0.
  2. load_use: pc_wen=0, ifid_wen=0, idex_bubble=1, exmem_wen=1, memwb_wen=1.
     - id_branch_taken and id_hlt are ignored this cycle and re-evaluated after the bubble.
  3. id_hlt: pc_wen=0, ifid_flush=1, everything else enabled.
     - Next state is DRAIN with drain_cnt=DRAIN_CYCLES.
  4. id_branch_taken: pc_wen=1, ifid_flush=1, everything else enabled.
     - This rule also applies when imem_stall=1: the branch target wins.
  5. imem_stall: pc_wen=0, ifid_flush=1, all other enables 1.
  6. Otherwise: all wen=1, ifid_flush=0, idex_bubble=0.
- DRAIN:
  - pc_wen=0, ifid_wen=0, idex_bubble=1.
  - exmem_wen and memwb_wen are equal to !dmem_stall.
  - drain_cnt decrements only on cycles with dmem_stall=0.
  - When drain_cnt==1 and dmem_stall=0, the next state is HALTED.
- HALTED:
  - pc_wen, ifid_wen, exmem_wen and memwb_wen are all 0; idex_bubble=1; halted=1.
  - Only rst exits this state.
- stall_cycles: increments by 1 on every RUN cycle with pc_wen=0 (rules 1, 2, 3 and 5). It saturates at all ones.
- While rst=1: all wen, flush and bubble outputs are 0.
- Reset values: state=RUN, drain_cnt=0, halted=0, stall_cycles=0.

## Timing
- All control outputs are combinational from inputs and current state. They act on the same rising edge with zero-cycle latency.
- halted and stall_cycles are registered and update one edge after the causing condition.
- A load-use stall lasts exactly 1 cycle: after the bubble, ID/EX holds ex_memread=0.
- HLT in ID at edge N:
  - DRAIN covers edges N+1 through N+3.
  - halted=1 after edge N+3, assuming no dmem_stall.
  - Each dmem_stall cycle in DRAIN extends this by one cycle.
- Asserting rst mid-DRAIN or in HALTED immediately returns the block to RUN and clears the counters (asynchronous).
- Releasing rst: the first edge after deassertion is a normal RUN cycle.

## Test plan
- Load-use: ex_memread=1, ex_rd=5, id_rs=5, id_uses_rs=1 for one cycle → pc_wen=0, ifid_wen=0, idex_bubble=1; stall_cycles 0→1. With ex_rd=0 instead → no stall.
- Branch + imem stall: id_branch_taken=1, imem_stall=1 → pc_wen=1, ifid_flush=1; stall_cycles unchanged.
- dmem_stall during load_use and branch: dmem_stall=1 → all wen=0, idex_bubble=0, ifid_flush=0; stall_cycles increments.
- Halt drain: id_hlt=1 for one cycle, then quiet → halted rises exactly 3 edges later. Repeat with dmem_stall=1 for 2 cycles inside DRAIN → 5 edges.
- Saturation: hold imem_stall=1 for 65,540 cycles → stall_cycles=0xFFFF and stays there.
- Async reset: assert rst mid-DRAIN and in HALTED, away from a clock edge → halted=0, stall_cycles=0 immediately; after release, all inputs 0 → pc_wen=1.
